// File: rtl/gshare_pht.sv
// Pattern history table of 2-bit saturating counters with a registered D-stage prediction.
// Optional macro GSHARE_XOR_EN: index = PC bits XOR history (gshare); undefined = history only (GAg).
module gshare_pht #(
    parameter int          IDX_W     = 3,
    parameter int          PC_LSB    = 2,
    parameter logic [1:0]  CNT_RESET = 2'b01,
    parameter int          PERF_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       Fpc,
    input  logic [IDX_W-1:0]  globalhistoryout,
    input  logic              Dstall,
    input  logic              Dflush,
    output logic              branchcircuitout,
    output logic [IDX_W-1:0]  Dindex,
    input  logic              Eupdate,
    input  logic [IDX_W-1:0]  Eindex,
    input  logic              Etaken,
    input  logic              Emispredict,
    output logic [PERF_W-1:0] mispredict_count
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0]       pht [ENTRIES];
    logic [IDX_W-1:0] fidx;
    logic [1:0]       upd_val;
    logic             pred;
    logic             unused_fpc;

`ifdef GSHARE_XOR_EN
    assign fidx = Fpc[PC_LSB+IDX_W-1:PC_LSB] ^ globalhistoryout;
`else
    assign fidx = globalhistoryout;
`endif

    // Only a slice of the PC (or none of it, in GAg mode) feeds the index.
    assign unused_fpc = ^Fpc;

    always_comb begin
        upd_val = pht[Eindex];
        if (Etaken) begin
            if (pht[Eindex] != 2'b11)
                upd_val = pht[Eindex] + 2'b01;
        end else begin
            if (pht[Eindex] != 2'b00)
                upd_val = pht[Eindex] - 2'b01;
        end
    end

    // Write-first: a lookup hitting the entry being trained sees the trained value.
    always_comb begin
        pred = pht[fidx][1];
        if (Eupdate && (Eindex == fidx))
            pred = upd_val[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++)
                pht[i] <= CNT_RESET;
        end else if (Eupdate) begin
            pht[Eindex] <= upd_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branchcircuitout <= 1'b0;
            Dindex           <= '0;
        end else if (Dflush) begin
            branchcircuitout <= 1'b0;
            Dindex           <= '0;
        end else if (!Dstall) begin
            branchcircuitout <= pred;
            Dindex           <= fidx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mispredict_count <= '0;
        else if (Eupdate && Emispredict && (mispredict_count != {PERF_W{1'b1}}))
            mispredict_count <= mispredict_count + 1'b1;
    end

endmodule

// File: tb/tb_gshare_pht.sv
// Randomized scoreboard bench for gshare_pht against a table-of-integers reference model.
module tb_gshare_pht;

    localparam int IDX_W  = 3;
    localparam int PERF_W = 4;
    localparam int PMAX   = (1 << PERF_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       Fpc = '0;
    logic [IDX_W-1:0]  globalhistoryout = '0;
    logic              Dstall = 1'b0;
    logic              Dflush = 1'b0;
    logic              branchcircuitout;
    logic [IDX_W-1:0]  Dindex;
    logic              Eupdate = 1'b0;
    logic [IDX_W-1:0]  Eindex = '0;
    logic              Etaken = 1'b0;
    logic              Emispredict = 1'b0;
    logic [PERF_W-1:0] mispredict_count;

    gshare_pht #(.IDX_W(IDX_W), .PC_LSB(2), .CNT_RESET(2'b01), .PERF_W(PERF_W)) dut (
        .clk(clk), .rst_n(rst_n), .Fpc(Fpc), .globalhistoryout(globalhistoryout),
        .Dstall(Dstall), .Dflush(Dflush), .branchcircuitout(branchcircuitout),
        .Dindex(Dindex), .Eupdate(Eupdate), .Eindex(Eindex), .Etaken(Etaken),
        .Emispredict(Emispredict), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct { int b; int d; int m; } exp_t;
    exp_t q[$];

    int checks = 0;
    int failures = 0;

    // Reference model: counter values as plain integers 0..3.
    int ctr [8];
    int m_b, m_d, m_m;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) ctr[i] = 1;
        m_b = 0; m_d = 0; m_m = 0;
    endtask

    task automatic push_state();
        exp_t e;
        e.b = m_b; e.d = m_d; e.m = m_m;
        q.push_back(e);
    endtask

    task automatic step(input logic [31:0] pc, input int h, input bit st, input bit fl,
                        input bit eu, input int ei, input bit et, input bit em);
        int fi;
        @(negedge clk);
        rst_n = 1'b1;
        Fpc = pc; globalhistoryout = h[IDX_W-1:0];
        Dstall = st; Dflush = fl;
        Eupdate = eu; Eindex = ei[IDX_W-1:0]; Etaken = et; Emispredict = em;
`ifdef GSHARE_XOR_EN
        fi = ((pc >> 2) & 7) ^ h;
`else
        fi = h;
`endif
        if (eu) begin
            if (et) ctr[ei] = (ctr[ei] == 3) ? 3 : ctr[ei] + 1;
            else    ctr[ei] = (ctr[ei] == 0) ? 0 : ctr[ei] - 1;
            if (em && m_m < PMAX) m_m++;
        end
        if (fl) begin
            m_b = 0; m_d = 0;
        end else if (!st) begin
            m_b = (ctr[fi] >= 2) ? 1 : 0;
            m_d = fi;
        end
        push_state();
    endtask

    task automatic idle(input logic [31:0] pc, input int h);
        step(pc, h, 0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset(input int cycles);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        Eupdate = 1'b0; Dstall = 1'b0; Dflush = 1'b0;
        #1;
        check("async_rst_bco", int'(branchcircuitout), 0);
        check("async_rst_dindex", int'(Dindex), 0);
        check("async_rst_mcount", int'(mispredict_count), 0);
        model_reset();
        push_state();
        repeat (cycles - 1) begin
            @(negedge clk);
            push_state();
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("bco", int'(branchcircuitout), e.b);
                check("dindex", int'(Dindex), e.d);
                check("mcount", int'(mispredict_count), e.m);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        model_reset();
        #1;
        check("rst_bco", int'(branchcircuitout), 0);
        check("rst_dindex", int'(Dindex), 0);
        check("rst_mcount", int'(mispredict_count), 0);
        repeat (2) @(negedge clk);

        idle(32'h0, 0);
        for (int i = 0; i < 8; i++) idle(32'h0, i);

        // Forwarding: entry 2 weak-NT trained taken in the same cycle it is looked up.
        step(32'h0, 2, 0, 0, 1, 2, 1, 0);
        idle(32'h0, 2);

        repeat (2) step(32'h0, 0, 0, 0, 1, 5, 1, 0);
        idle(32'h0, 5);
        repeat (3) step(32'h0, 0, 0, 0, 1, 5, 1, 0);
        idle(32'h0, 5);
        repeat (2) step(32'h0, 0, 0, 0, 1, 5, 0, 0);
        idle(32'h0, 5);

        idle(32'h14, 3);

        idle(32'h0, 5);
        for (int i = 0; i < 3; i++) step($urandom, $urandom_range(0, 7), 1, 0, 0, 0, 0, 0);
        step($urandom, $urandom_range(0, 7), 1, 1, 0, 0, 0, 0);
        idle(32'h0, 2);

        for (int i = 0; i < 20; i++)
            step(32'h0, i % 8, 0, 0, 1, $urandom_range(0, 7), 1'($urandom), 1);

        do_reset(2);
        for (int i = 0; i < 8; i++) idle(32'h0, i);

        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset(3);
            step($urandom, $urandom_range(0, 7),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                 1'($urandom), $urandom_range(0, 7), 1'($urandom),
                 ($urandom_range(0, 3) == 0));
        end
        idle(32'h0, 0);

        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
